// File: rtl/iso7816_brg_os.sv
// ISO7816 baud-rate generator with fractional F/D phase accumulator,
// 2^OS_LOG2 sub-ETU sample strobes, TX/RX strobe split with a lagged
// receive strobe in transmit mode, and a saturating ETU counter with a
// timeout compare.
//
// Strobe semantics: every output strobe is a single-cycle, registered
// pulse with no back-pressure. A tick computed in cycle t is visible in
// cycle t+1. The block stays silent after reset until a sync has loaded
// the phase accumulator.
module iso7816_brg_os #(
  parameter int W        = 15,
  parameter int OS_LOG2  = 0,
  parameter int TXRX_LAG = 3,
  parameter int CW       = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   sync,
  input  logic                                   run,
  input  logic                                   txrx,
  input  logic                                   clr_cnt,
  input  logic [W-1:0]                           cfg_F,
  input  logic [W-1:0]                           cfg_D,
  input  logic [W-1:0]                           cfg_init,
  input  logic [CW-1:0]                          cfg_timeout,
  output logic                                   stb_smp,
  output logic                                   stb_tx,
  output logic                                   stb_rx,
  output logic [((OS_LOG2 > 0) ? OS_LOG2 : 1)-1:0] smp_idx,
  output logic [CW-1:0]                          etu_cnt,
  output logic                                   timeout
);

  localparam int AW = W + OS_LOG2 + 1;
  localparam int IW = (OS_LOG2 > 0) ? OS_LOG2 : 1;
  localparam int NS = 1 << OS_LOG2;

  // State registers
  logic [AW-1:0]       acc_q, acc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [TXRX_LAG-1:0] dl_q, dl_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                synced_q, synced_d;
  logic                stb_smp_q, stb_smp_d;
  logic                stb_tx_q, stb_tx_d;
  logic                stb_rx_q, stb_rx_d;
  logic [IW-1:0]       smp_idx_q, smp_idx_d;
  logic                timeout_q, timeout_d;

  // Datapath helpers
  logic [AW-1:0] deff;
  logic [AW-1:0] f_ext;
  logic [AW-1:0] init_ext;
  logic [AW-1:0] sum;
  logic [IW-1:0] idx_inc;
  logic [CW-1:0] cnt_inc;
  logic          last_smp;
  logic          tick_smp;
  logic          tick_etu;
  logic          tx_tick;

  // Effective increment is D scaled by the oversampling ratio, so the
  // accumulator wraps 2^OS_LOG2 times per ETU.
  assign deff     = {{(OS_LOG2 + 1){1'b0}}, cfg_D} << OS_LOG2;
  assign f_ext    = {{(OS_LOG2 + 1){1'b0}}, cfg_F};
  assign init_ext = {{(OS_LOG2 + 1){1'b0}}, cfg_init};
  assign sum      = acc_q + deff;
  // Without oversampling the index never moves.
  assign idx_inc  = (OS_LOG2 == 0) ? '0 : idx_q + IW'(1);
  assign last_smp = (idx_q == IW'(NS - 1));
  assign cnt_inc  = cnt_q + CW'(1);

  // Next-state: accumulator, sub index, delay line, counter and strobes
  always_comb begin
    acc_d     = acc_q;
    idx_d     = idx_q;
    dl_d      = dl_q;
    cnt_d     = cnt_q;
    synced_d  = synced_q;
    smp_idx_d = smp_idx_q;
    stb_smp_d = 1'b0;
    stb_tx_d  = 1'b0;
    stb_rx_d  = 1'b0;
    timeout_d = 1'b0;
    tick_smp  = 1'b0;
    tick_etu  = 1'b0;
    tx_tick   = 1'b0;

    if (sync) begin
      // Phase reload wins over everything; pending lagged strobes are dropped.
      acc_d     = init_ext;
      idx_d     = '0;
      smp_idx_d = '0;
      dl_d      = '0;
      cnt_d     = '0;
      synced_d  = 1'b1;
    end else begin
      if (run && synced_q) begin
        if (sum >= f_ext) begin
          acc_d    = sum - f_ext;
          tick_smp = 1'b1;
        end else begin
          acc_d = sum;
        end
        tick_etu = tick_smp && last_smp;
        tx_tick  = tick_etu && txrx;
        if (tick_smp) begin
          idx_d     = idx_inc;
          smp_idx_d = idx_q;
        end
        // The receive strobe in transmit mode trails the tick by TXRX_LAG
        // cycles; the line only advances while running.
        dl_d      = (dl_q << 1) | TXRX_LAG'(tx_tick);
        stb_smp_d = tick_smp;
        stb_tx_d  = tx_tick;
        stb_rx_d  = (tick_etu && !txrx) || dl_q[TXRX_LAG-1];
      end

      // A clear coinciding with an ETU tick leaves the counter at zero.
      if (clr_cnt) begin
        cnt_d = '0;
      end else if (tick_etu && (cnt_q != '1)) begin
        cnt_d     = cnt_inc;
        timeout_d = (cfg_timeout != '0) && (cnt_inc == cfg_timeout);
      end
    end
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      idx_q     <= '0;
      dl_q      <= '0;
      cnt_q     <= '0;
      synced_q  <= 1'b0;
      smp_idx_q <= '0;
      stb_smp_q <= 1'b0;
      stb_tx_q  <= 1'b0;
      stb_rx_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      dl_q      <= dl_d;
      cnt_q     <= cnt_d;
      synced_q  <= synced_d;
      smp_idx_q <= smp_idx_d;
      stb_smp_q <= stb_smp_d;
      stb_tx_q  <= stb_tx_d;
      stb_rx_q  <= stb_rx_d;
      timeout_q <= timeout_d;
    end
  end

  assign stb_smp = stb_smp_q;
  assign stb_tx  = stb_tx_q;
  assign stb_rx  = stb_rx_q;
  assign smp_idx = smp_idx_q;
  assign etu_cnt = cnt_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_iso7816_brg_os.sv
// Bench for iso7816_brg_os: instance A uses default parameters, instance B
// uses 4x oversampling, a one-cycle TX/RX lag and a 3-bit ETU counter.
module tb_iso7816_brg_os;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A signals
  logic        a_sync, a_run, a_txrx, a_clr;
  logic [14:0] a_f, a_d, a_init;
  logic [15:0] a_tmo;
  logic        a_stb_smp, a_stb_tx, a_stb_rx, a_timeout;
  logic [0:0]  a_smp_idx;
  logic [15:0] a_cnt;

  // Instance B signals
  logic        b_sync, b_run, b_txrx, b_clr;
  logic [14:0] b_f, b_d, b_init;
  logic [2:0]  b_tmo;
  logic        b_stb_smp, b_stb_tx, b_stb_rx, b_timeout;
  logic [1:0]  b_smp_idx;
  logic [2:0]  b_cnt;

  iso7816_brg_os u_a (
    .clk(clk), .rst_n(rst_n), .sync(a_sync), .run(a_run), .txrx(a_txrx),
    .clr_cnt(a_clr), .cfg_F(a_f), .cfg_D(a_d), .cfg_init(a_init),
    .cfg_timeout(a_tmo), .stb_smp(a_stb_smp), .stb_tx(a_stb_tx),
    .stb_rx(a_stb_rx), .smp_idx(a_smp_idx), .etu_cnt(a_cnt),
    .timeout(a_timeout)
  );

  iso7816_brg_os #(.W(15), .OS_LOG2(2), .TXRX_LAG(1), .CW(3)) u_b (
    .clk(clk), .rst_n(rst_n), .sync(b_sync), .run(b_run), .txrx(b_txrx),
    .clr_cnt(b_clr), .cfg_F(b_f), .cfg_D(b_d), .cfg_init(b_init),
    .cfg_timeout(b_tmo), .stb_smp(b_stb_smp), .stb_tx(b_stb_tx),
    .stb_rx(b_stb_rx), .smp_idx(b_smp_idx), .etu_cnt(b_cnt),
    .timeout(b_timeout)
  );

  // Scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock; inputs and samples both land 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_do_sync();
    a_sync = 1'b1;
    a_run  = 1'b0;
    step();
    a_sync = 1'b0;
  endtask

  task automatic b_do_sync();
    b_sync = 1'b1;
    b_run  = 1'b0;
    step();
    b_sync = 1'b0;
  endtask

  // Vector table for instance A: sync in cycle 0, run in cycles 1..n,
  // observe cycles 2..n+1.
  typedef struct {
    logic [14:0] f;
    logic [14:0] d;
    logic [14:0] init;
    logic        txrx;
    logic [15:0] tmo;
    int          n;
    int          exp_rx;
    int          exp_tx;
    int          exp_first_rx;
    int          exp_first_tx;
    int          exp_cnt;
    int          exp_tmo;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int rx, tx, frx, ftx, tmo, last_rx, bad_sp, cnt_x;
    int nsmp, last_smp, bad;

    vecs[0] = '{15'd372, 15'd1,  15'd186, 1'b0, 16'd2,   1000, 3,   0,  187, 0,   3,   1};
    vecs[1] = '{15'd372, 15'd32, 15'd58,  1'b0, 16'd400, 3720, 320, 0,  11,  0,   320, 0};
    vecs[2] = '{15'd372, 15'd1,  15'd186, 1'b1, 16'd0,   200,  1,   1,  190, 187, 1,   0};
    vecs[3] = '{15'd40,  15'd1,  15'd0,   1'b0, 16'd3,   130,  3,   0,  41,  0,   3,   1};
    vecs[4] = '{15'd10,  15'd3,  15'd9,   1'b1, 16'd0,   50,   15,  15, 5,   2,   15,  0};
    vecs[5] = '{15'd10,  15'd9,  15'd0,   1'b0, 16'd5,   20,   18,  0,  3,   0,   18,  1};

    rst_n  = 1'b0;
    a_sync = 0; a_run = 0; a_txrx = 0; a_clr = 0;
    a_f = '0; a_d = '0; a_init = '0; a_tmo = '0;
    b_sync = 0; b_run = 0; b_txrx = 0; b_clr = 0;
    b_f = '0; b_d = '0; b_init = '0; b_tmo = '0;
    repeat (3) step();
    check("reset_a_outputs", {a_stb_smp, a_stb_tx, a_stb_rx, a_timeout, a_smp_idx, a_cnt}, 0);
    check("reset_b_outputs", {b_stb_smp, b_stb_tx, b_stb_rx, b_timeout, b_smp_idx, b_cnt}, 0);
    rst_n = 1'b1;
    step();

    // ---- table-driven vectors on instance A ----
    for (int i = 0; i < 6; i++) begin
      a_f = vecs[i].f; a_d = vecs[i].d; a_init = vecs[i].init;
      a_txrx = vecs[i].txrx; a_tmo = vecs[i].tmo;
      a_do_sync();
      rx = 0; tx = 0; frx = 0; ftx = 0; tmo = 0; last_rx = 0; bad_sp = 0;
      for (int c = 1; c <= vecs[i].n; c++) begin
        a_run = 1'b1;
        step();
        if (a_stb_rx) begin
          rx++;
          if (frx == 0) frx = c + 1;
          if (last_rx != 0 && (c + 1 - last_rx < 11 || c + 1 - last_rx > 12)) bad_sp++;
          last_rx = c + 1;
        end
        if (a_stb_tx) begin
          tx++;
          if (ftx == 0) ftx = c + 1;
        end
        if (a_timeout) tmo++;
      end
      a_run = 1'b0;
      check($sformatf("v%0d_rx_count", i), rx, vecs[i].exp_rx);
      check($sformatf("v%0d_tx_count", i), tx, vecs[i].exp_tx);
      check($sformatf("v%0d_first_rx", i), frx, vecs[i].exp_first_rx);
      check($sformatf("v%0d_first_tx", i), ftx, vecs[i].exp_first_tx);
      check($sformatf("v%0d_etu_cnt", i), a_cnt, vecs[i].exp_cnt);
      check($sformatf("v%0d_timeouts", i), tmo, vecs[i].exp_tmo);
      if (i == 1) check("v1_rx_spacing_bad", bad_sp, 0);
    end

    // ---- sync in cycle 188 suppresses the lagged stb_rx ----
    a_f = 15'd372; a_d = 15'd1; a_init = 15'd186; a_txrx = 1'b1; a_tmo = '0;
    a_do_sync();
    a_run = 1'b1;
    repeat (186) step();
    check("lag_stb_tx_187", a_stb_tx, 1);
    step();
    a_sync = 1'b1;
    step();
    a_sync = 1'b0;
    rx = 0;
    for (int c = 189; c <= 200; c++) begin
      step();
      if (a_stb_rx) rx++;
    end
    a_run = 1'b0;
    check("lag_rx_suppressed", rx, 0);
    check("lag_cnt_after_sync", a_cnt, 0);

    // ---- timeout, no re-fire, clr_cnt and fire again ----
    a_f = 15'd40; a_d = 15'd1; a_init = 15'd0; a_txrx = 1'b0; a_tmo = 16'd3;
    a_do_sync();
    a_run = 1'b1;
    repeat (120) step();
    check("tmo_cnt_at_121", a_cnt, 3);
    check("tmo_pulse_at_121", a_timeout, 1);
    tmo = 0;
    for (int c = 0; c < 130; c++) begin
      step();
      if (a_timeout) tmo++;
    end
    check("tmo_no_refire", tmo, 0);
    check("tmo_cnt_6", a_cnt, 6);
    a_run = 1'b0; a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    check("clr_cnt_zero", a_cnt, 0);
    a_run = 1'b1;
    tmo = 0;
    for (int c = 0; c < 120; c++) begin
      step();
      if (a_timeout) tmo++;
    end
    a_run = 1'b0;
    check("tmo_after_clr", tmo, 1);
    check("tmo_after_clr_cnt", a_cnt, 3);

    // ---- clr_cnt coinciding with a tick leaves zero ----
    a_do_sync();
    a_run = 1'b1;
    repeat (39) step();
    a_clr = 1'b1;
    step();
    a_clr = 1'b0; a_run = 1'b0;
    check("clr_tick_rx", a_stb_rx, 1);
    check("clr_tick_cnt", a_cnt, 0);

    // ---- oversampling on instance B ----
    b_f = 15'd372; b_d = 15'd1; b_init = 15'd0; b_txrx = 1'b0; b_tmo = '0;
    for (int k = 0; k < 8; k++) exp_q.push_back(2'(k % 4));
    b_do_sync();
    nsmp = 0; last_smp = 0; bad = 0; rx = 0; frx = 0;
    for (int c = 1; c <= 800; c++) begin
      b_run = 1'b1;
      step();
      if (b_stb_smp) begin
        nsmp++;
        if (last_smp != 0 && c + 1 - last_smp != 93) bad++;
        if (last_smp == 0 && c + 1 != 94) bad++;
        last_smp = c + 1;
        if (exp_q.size() > 0) check("os_smp_idx", b_smp_idx, exp_q.pop_front());
      end
      if (b_stb_rx) begin
        rx++;
        if (frx == 0) frx = c + 1;
        if (!(b_stb_smp && b_smp_idx == 2'd3)) bad++;
      end
    end
    b_run = 1'b0;
    check("os_smp_count", nsmp, 8);
    check("os_spacing_bad", bad, 0);
    check("os_rx_count", rx, 2);
    check("os_first_rx", frx, 373);
    check("os_queue_empty", exp_q.size(), 0);

    // ---- B: TX/RX lag of 1, counter saturation, single timeout ----
    b_f = 15'd8; b_d = 15'd1; b_init = 15'd0; b_txrx = 1'b1; b_tmo = 3'd7;
    b_do_sync();
    rx = 0; tx = 0; frx = 0; ftx = 0; tmo = 0;
    for (int c = 1; c <= 100; c++) begin
      b_run = 1'b1;
      step();
      if (b_stb_rx) begin rx++; if (frx == 0) frx = c + 1; end
      if (b_stb_tx) begin tx++; if (ftx == 0) ftx = c + 1; end
      if (b_timeout) tmo++;
    end
    b_run = 1'b0;
    check("sat_first_tx", ftx, 9);
    check("sat_first_rx", frx, 10);
    check("sat_tx_count", tx, 12);
    check("sat_rx_count", rx, 12);
    check("sat_cnt", b_cnt, 7);
    check("sat_timeouts", tmo, 1);

    // ---- asynchronous reset mid-ETU ----
    a_f = 15'd40; a_d = 15'd1; a_init = 15'd0; a_txrx = 1'b0; a_tmo = '0;
    a_do_sync();
    a_run = 1'b1;
    repeat (50) step();
    check("pre_rst_cnt", a_cnt, 1);
    #3 rst_n = 1'b0;
    #1;
    cnt_x = a_cnt;
    check("async_rst_a", {a_stb_smp, a_stb_tx, a_stb_rx, a_timeout, a_smp_idx}, 0);
    check("async_rst_a_cnt", cnt_x, 0);
    check("async_rst_b", {b_stb_smp, b_stb_tx, b_stb_rx, b_timeout, b_smp_idx, b_cnt}, 0);
    step();
    rst_n = 1'b1;
    a_run = 1'b1; b_run = 1'b1;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (a_stb_smp || a_stb_tx || a_stb_rx || b_stb_smp || b_stb_tx || b_stb_rx) bad++;
    end
    a_run = 1'b0; b_run = 1'b0;
    check("no_strobe_before_sync", bad, 0);
    a_do_sync();
    a_run = 1'b1;
    repeat (40) step();
    a_run = 1'b0;
    check("strobe_after_sync", a_stb_rx, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
